// File: rtl/term_pkg.sv
// term_pkg: shared constants and types for the terminal write controller.
// Optional feature macro: TERM_CLEAR_EN (form-feed screen clear sweep).
package term_pkg;

  // Control and printable-range codes understood by the controller
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_FF       = 8'h0C;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  // Default screen geometry and fill character
  localparam int         TERM_COLS = 80;
  localparam int         TERM_ROWS = 30;
  localparam logic [6:0] TERM_FILL = 7'h20;

  // Character-cell address as seen by the char generator: {row, col}
  typedef struct packed {
    logic [4:0] row;
    logic [6:0] col;
  } char_addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } term_state_t;

  // True for bytes that are drawn as glyphs
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_PRINT_LO) && (b <= ASCII_PRINT_HI);
  endfunction

endpackage

// File: rtl/term_cursor.sv
// term_cursor: row/col position counter with separate field arithmetic.
// Controls in priority order: zero, inc (advance with wrap), retreat
// (col-1, stops at col 0), cr (col=0), lf (row+1 with wrap, col kept).
module term_cursor
  import term_pkg::*;
#(
  parameter int COLS = TERM_COLS,
  parameter int ROWS = TERM_ROWS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        zero,
  input  logic        inc,
  input  logic        retreat,
  input  logic        cr,
  input  logic        lf,
  output logic [11:0] pos
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  logic [4:0] row_reg, row_next;
  logic [6:0] col_reg, col_next;

  // Next position: col never exceeds COL_LAST and carries into row explicitly
  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (zero) begin
      row_next = '0;
      col_next = '0;
    end else if (inc) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? 5'd0 : row_reg + 5'd1;
      end else begin
        col_next = col_reg + 7'd1;
      end
    end else if (retreat) begin
      if (col_reg != 7'd0) begin
        col_next = col_reg - 7'd1;
      end
    end else if (cr) begin
      col_next = '0;
    end else if (lf) begin
      row_next = (row_reg == ROW_LAST) ? 5'd0 : row_reg + 5'd1;
    end
  end

  // Position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg <= '0;
      col_reg <= '0;
    end else begin
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  assign pos = {row_reg, col_reg};

endmodule

// File: rtl/term_write_ctrl.sv
// term_write_ctrl: decodes received bytes into char generator writes and
// owns the cursor. Printable bytes write at the cursor and advance it;
// CR/LF/BS move it; other codes are accepted and dropped.
// Optional feature macro: TERM_CLEAR_EN -- when defined, FF (0x0C) starts a
// COLS*ROWS cycle sweep writing the fill character to every cell.
module term_write_ctrl
  import term_pkg::*;
#(
  parameter int         COLS      = TERM_COLS,
  parameter int         ROWS      = TERM_ROWS,
  parameter logic [6:0] FILL_CHAR = TERM_FILL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        char_we,
  output logic [11:0] char_addr,
  output logic [6:0]  char_value,
  output logic [11:0] cursor_addr,
  output logic        busy
);

  term_state_t state_reg, state_next;
  logic        char_we_reg, char_we_next;
  logic [11:0] char_addr_reg, char_addr_next;
  logic [6:0]  char_value_reg, char_value_next;
  logic        byte_ready_reg, byte_ready_next;

  logic        cur_zero, cur_inc, cur_retreat, cur_cr, cur_lf;
  logic [11:0] cursor_pos;
  char_addr_t  cur;
  logic        accept;

  assign cur    = char_addr_t'(cursor_pos);
  assign accept = byte_valid & byte_ready_reg;

  term_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk     (clk),
    .rst_n   (rst_n),
    .zero    (cur_zero),
    .inc     (cur_inc),
    .retreat (cur_retreat),
    .cr      (cur_cr),
    .lf      (cur_lf),
    .pos     (cursor_pos)
  );

`ifdef TERM_CLEAR_EN
  localparam logic [11:0] LAST_ADDR = {5'(ROWS - 1), 7'(COLS - 1)};

  logic        busy_reg, busy_next;
  logic        sweep_zero, sweep_inc;
  logic [11:0] sweep_pos;

  // Second counter instance walks every cell during a clear
  term_cursor #(.COLS(COLS), .ROWS(ROWS)) u_sweep (
    .clk     (clk),
    .rst_n   (rst_n),
    .zero    (sweep_zero),
    .inc     (sweep_inc),
    .retreat (1'b0),
    .cr      (1'b0),
    .lf      (1'b0),
    .pos     (sweep_pos)
  );
`endif

  // Next-state, write-port and cursor-control decode
  always_comb begin
    state_next      = state_reg;
    char_we_next    = 1'b0;
    char_addr_next  = char_addr_reg;
    char_value_next = char_value_reg;
    byte_ready_next = 1'b1;
    cur_zero        = 1'b0;
    cur_inc         = 1'b0;
    cur_retreat     = 1'b0;
    cur_cr          = 1'b0;
    cur_lf          = 1'b0;
`ifdef TERM_CLEAR_EN
    busy_next       = 1'b0;
    sweep_zero      = 1'b0;
    sweep_inc       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_printable(byte_in)) begin
            char_we_next    = 1'b1;
            char_addr_next  = cursor_pos;
            char_value_next = byte_in[6:0];
            cur_inc         = 1'b1;
          end else if (byte_in == ASCII_CR) begin
            cur_cr = 1'b1;
          end else if (byte_in == ASCII_LF) begin
            cur_lf = 1'b1;
          end else if (byte_in == ASCII_BS) begin
            // Backspace stops at column 0; it never retreats a row
            if (cur.col != 7'd0) begin
              cur_retreat     = 1'b1;
              char_we_next    = 1'b1;
              char_addr_next  = {cur.row, cur.col - 7'd1};
              char_value_next = FILL_CHAR;
            end
`ifdef TERM_CLEAR_EN
          end else if (byte_in == ASCII_FF) begin
            // First sweep write is issued on the entry edge so busy and
            // the write pulses line up exactly
            state_next      = CLEAR;
            byte_ready_next = 1'b0;
            busy_next       = 1'b1;
            char_we_next    = 1'b1;
            char_addr_next  = sweep_pos;
            char_value_next = FILL_CHAR;
            sweep_inc       = 1'b1;
`endif
          end
        end
      end
`ifdef TERM_CLEAR_EN
      CLEAR: begin
        byte_ready_next = 1'b0;
        busy_next       = 1'b1;
        if (char_addr_reg == LAST_ADDR) begin
          // Last cell is being presented now; finish on this edge
          state_next      = IDLE;
          byte_ready_next = 1'b1;
          busy_next       = 1'b0;
          cur_zero        = 1'b1;
          sweep_zero      = 1'b1;
        end else begin
          char_we_next    = 1'b1;
          char_addr_next  = sweep_pos;
          char_value_next = FILL_CHAR;
          sweep_inc       = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      char_we_reg    <= 1'b0;
      char_addr_reg  <= '0;
      char_value_reg <= '0;
      byte_ready_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      char_we_reg    <= char_we_next;
      char_addr_reg  <= char_addr_next;
      char_value_reg <= char_value_next;
      byte_ready_reg <= byte_ready_next;
    end
  end

`ifdef TERM_CLEAR_EN
  // Busy flag tracks the clear sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= busy_next;
    end
  end
  assign busy = busy_reg;
`else
  assign busy = 1'b0;
`endif

  assign byte_ready  = byte_ready_reg;
  assign char_we     = char_we_reg;
  assign char_addr   = char_addr_reg;
  assign char_value  = char_value_reg;
  assign cursor_addr = cursor_pos;

endmodule

// File: tb/tb_term_write_ctrl.sv
// Directed bench for term_write_ctrl; clear-sweep steps are built when
// TERM_CLEAR_EN is defined, otherwise 0x0C is checked as an ignored code.
module tb_term_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        char_we;
  logic [11:0] char_addr;
  logic [6:0]  char_value;
  logic [11:0] cursor_addr;
  logic        busy;

  int cmp_count = 0;
  int err_count = 0;

  term_write_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .char_we     (char_we),
    .char_addr   (char_addr),
    .char_value  (char_value),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte, wait (bounded) for acceptance, return #1 after the accept edge
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) chk("ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    $display("tx byte=%02h we=%0b addr=%03h val=%02h cur=%03h busy=%0b",
             b, char_we, char_addr, char_value, cursor_addr, busy);
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  initial begin
    // Reset values while held in reset
    #1;
    chk("rst_we",     32'(char_we),     32'd0);
    chk("rst_addr",   32'(char_addr),   32'h000);
    chk("rst_value",  32'(char_value),  32'h00);
    chk("rst_cursor", 32'(cursor_addr), 32'h000);
    chk("rst_busy",   32'(busy),        32'd0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(byte_ready), 32'd1);

    // First printable write: latency 1, cursor advances
    send(8'h41);
    chk("A_we",     32'(char_we),     32'd1);
    chk("A_addr",   32'(char_addr),   32'h000);
    chk("A_value",  32'(char_value),  32'h41);
    chk("A_cursor", 32'(cursor_addr), 32'h001);
    @(posedge clk);
    #1;
    chk("A_we_drop",   32'(char_we),   32'd0);
    chk("A_addr_hold", 32'(char_addr), 32'h000);

    // End of row 0 carries to row 1
    send_n(8'h61, 78);
    chk("col79_cursor", 32'(cursor_addr), 32'h04F);
    send(8'h5A);
    chk("Z_addr",   32'(char_addr),   32'h04F);
    chk("Z_value",  32'(char_value),  32'h5A);
    chk("Z_cursor", 32'(cursor_addr), 32'h080);

    // Last cell of screen wraps to {0,0}
    send_n(8'h0A, 28);
    send_n(8'h62, 79);
    chk("last_cursor", 32'(cursor_addr), 32'hECF);
    send(8'h51);
    chk("Q_we",     32'(char_we),     32'd1);
    chk("Q_addr",   32'(char_addr),   32'hECF);
    chk("Q_value",  32'(char_value),  32'h51);
    chk("Q_cursor", 32'(cursor_addr), 32'h000);

    // Move to {3,10}, then BS / CR / BS-at-col-0
    send_n(8'h0A, 3);
    send_n(8'h63, 10);
    chk("r3c10_cursor", 32'(cursor_addr), 32'h18A);
    send(8'h08);
    chk("BS_we",     32'(char_we),     32'd1);
    chk("BS_addr",   32'(char_addr),   32'h189);
    chk("BS_value",  32'(char_value),  32'h20);
    chk("BS_cursor", 32'(cursor_addr), 32'h189);
    send(8'h78);
    chk("x_cursor", 32'(cursor_addr), 32'h18A);
    send(8'h0D);
    chk("CR_we",     32'(char_we),     32'd0);
    chk("CR_cursor", 32'(cursor_addr), 32'h180);
    send(8'h08);
    chk("BS0_we",     32'(char_we),     32'd0);
    chk("BS0_cursor", 32'(cursor_addr), 32'h180);

    // LF wraps the bottom row, column preserved
    send_n(8'h64, 5);
    send_n(8'h0A, 26);
    chk("r29c5_cursor", 32'(cursor_addr), 32'hE85);
    send(8'h0A);
    chk("LF_wrap_we",     32'(char_we),     32'd0);
    chk("LF_wrap_cursor", 32'(cursor_addr), 32'h005);

    // Ignored codes: accepted, no write, address/value held
    send(8'h7F);
    chk("DEL_we",     32'(char_we),     32'd0);
    chk("DEL_cursor", 32'(cursor_addr), 32'h005);
    chk("DEL_addr",   32'(char_addr),   32'h184);
    chk("DEL_value",  32'(char_value),  32'h64);
    send(8'h00);
    chk("NUL_ready",  32'(byte_ready),  32'd1);
    chk("NUL_cursor", 32'(cursor_addr), 32'h005);

`ifdef TERM_CLEAR_EN
    begin
      int pulses, bad_we, bad_addr, bad_val, bad_rdy, guard;
      logic [11:0] ea;
      pulses = 0; bad_we = 0; bad_addr = 0; bad_val = 0; bad_rdy = 0; guard = 0;
      send(8'h0C);
      chk("FF_busy",  32'(busy),       32'd1);
      chk("FF_ready", 32'(byte_ready), 32'd0);
      byte_in    = 8'h42;
      byte_valid = 1'b1;
      while (busy && guard < 3000) begin
        ea = {5'(pulses / 80), 7'(pulses % 80)};
        if (char_we !== 1'b1) bad_we++;
        if (char_addr !== ea) bad_addr++;
        if (char_value !== 7'h20) bad_val++;
        if (byte_ready !== 1'b0) bad_rdy++;
        pulses++;
        @(posedge clk);
        #1;
        guard++;
      end
      chk("clr_pulses",   32'(pulses),   32'd2400);
      chk("clr_bad_we",   32'(bad_we),   32'd0);
      chk("clr_bad_addr", 32'(bad_addr), 32'd0);
      chk("clr_bad_val",  32'(bad_val),  32'd0);
      chk("clr_bad_rdy",  32'(bad_rdy),  32'd0);
      chk("clr_end_we",     32'(char_we),     32'd0);
      chk("clr_end_cursor", 32'(cursor_addr), 32'h000);
      chk("clr_end_ready",  32'(byte_ready),  32'd1);
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      $display("tx byte=42 we=%0b addr=%03h val=%02h cur=%03h busy=%0b",
               char_we, char_addr, char_value, cursor_addr, busy);
      chk("B_we",     32'(char_we),     32'd1);
      chk("B_addr",   32'(char_addr),   32'h000);
      chk("B_value",  32'(char_value),  32'h42);
      chk("B_cursor", 32'(cursor_addr), 32'h001);

      // Start another sweep and abort it partway with reset
      send(8'h0C);
      repeat (999) @(posedge clk);
      #1;
      chk("mid_busy", 32'(busy), 32'd1);
    end
`else
    send(8'h0C);
    chk("FF_ign_we",     32'(char_we),     32'd0);
    chk("FF_ign_cursor", 32'(cursor_addr), 32'h005);
    chk("FF_ign_busy",   32'(busy),        32'd0);
    chk("FF_ign_ready",  32'(byte_ready),  32'd1);
`endif

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we",     32'(char_we),     32'd0);
    chk("arst_busy",   32'(busy),        32'd0);
    chk("arst_cursor", 32'(cursor_addr), 32'h000);
    chk("arst_addr",   32'(char_addr),   32'h000);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h07);
    chk("BEL_we",     32'(char_we),     32'd0);
    chk("BEL_cursor", 32'(cursor_addr), 32'h000);
    send(8'h85);
    chk("hi_we",     32'(char_we),     32'd0);
    chk("hi_cursor", 32'(cursor_addr), 32'h000);
    chk("hi_ready",  32'(byte_ready),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
